apb_requester: RTL and testbench

//   APB initiator: accepts single read/write commands on a valid/ready command port,

---
 rtl/apb_requester.sv | 146 ++++++++++++++
 tb/tb_apb_requester.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// APB initiator: takes one read/write command at a time, runs SETUP/ACCESS toward a
// decoded peripheral select, and returns read data plus error status on a response port.
module apb_requester #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NumSel        = 4,
  parameter int unsigned SelLsb        = 12,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  input  logic                 cmdWrite,
  input  logic [AddrWidth-1:0] cmdAddr,
  input  logic [DataWidth-1:0] cmdWData,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [DataWidth-1:0] rspRData,
  output logic                 rspErr,
  output logic [NumSel-1:0]    sel,
  output logic                 enable,
  output logic                 write,
  output logic [AddrWidth-1:0] addr,
  output logic [DataWidth-1:0] wData,
  input  logic [DataWidth-1:0] rData,
  input  logic                 ready,
  input  logic                 subErr
);

  localparam int unsigned IdxWidth = (NumSel > 1) ? $clog2(NumSel) : 1;
  localparam int unsigned CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t               state, state_n;
  logic [IdxWidth-1:0]  idx;
  logic                 idx_ok;
  logic [CntWidth-1:0]  cnt, cnt_n;
  logic                 timeout_hit;
  logic                 cmd_ready_n, rsp_valid_n, rsp_err_n, enable_n, write_n;
  logic [DataWidth-1:0] rsp_rdata_n, wdata_n;
  logic [AddrWidth-1:0] addr_n;
  logic [NumSel-1:0]    sel_n;

  // Select index decode; a single peripheral always decodes to index 0.
  assign idx         = (NumSel == 1) ? '0 : cmdAddr[SelLsb +: IdxWidth];
  assign idx_ok      = (32'(idx) < NumSel);
  assign timeout_hit = (TimeoutCycles != 0) && (cnt == CntWidth'(TimeoutCycles - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cmdReady <= 1'b1;
      rspValid <= 1'b0;
      rspRData <= '0;
      rspErr   <= 1'b0;
      sel      <= '0;
      enable   <= 1'b0;
      write    <= 1'b0;
      addr     <= '0;
      wData    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cmdReady <= cmd_ready_n;
      rspValid <= rsp_valid_n;
      rspRData <= rsp_rdata_n;
      rspErr   <= rsp_err_n;
      sel      <= sel_n;
      enable   <= enable_n;
      write    <= write_n;
      addr     <= addr_n;
      wData    <= wdata_n;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cmd_ready_n = cmdReady;
    rsp_valid_n = rspValid;
    rsp_rdata_n = rspRData;
    rsp_err_n   = rspErr;
    sel_n       = sel;
    enable_n    = enable;
    write_n     = write;
    addr_n      = addr;
    wdata_n     = wData;
    unique case (state)
      IDLE: begin
        if (cmdValid) begin
          cmd_ready_n = 1'b0;
          write_n     = cmdWrite;
          addr_n      = cmdAddr;
          wdata_n     = cmdWData;
          if (idx_ok) begin
            state_n = SETUP;
            sel_n   = NumSel'(1) << idx;
          end else begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
          end
        end
      end
      SETUP: begin
        state_n  = ACCESS;
        enable_n = 1'b1;
        cnt_n    = '0;
      end
      ACCESS: begin
        // A ready on the last allowed cycle still completes normally.
        if (ready || timeout_hit) begin
          state_n     = RESP;
          sel_n       = '0;
          enable_n    = 1'b0;
          rsp_valid_n = 1'b1;
          if (ready) begin
            rsp_err_n   = subErr;
            rsp_rdata_n = write ? '0 : rData;
          end else begin
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
          end
        end else begin
          cnt_n = cnt + CntWidth'(1);
        end
      end
      RESP: begin
        if (rspReady) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
          rsp_rdata_n = '0;
          rsp_err_n   = 1'b0;
          cmd_ready_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: directed scenarios plus random traffic, every cycle checked
// against a transaction-level model of the requester.
module tb_apb_requester;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned NSEL = 3;
  localparam int unsigned SLSB = 12;
  localparam int unsigned TMO  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmdValid, cmdReady, cmdWrite;
  logic [AW-1:0]   cmdAddr;
  logic [DW-1:0]   cmdWData;
  logic            rspValid, rspReady, rspErr;
  logic [DW-1:0]   rspRData;
  logic [NSEL-1:0] sel;
  logic            enable, write;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wData, rData;
  logic            ready, subErr;

  int vectors = 0;
  int miscompares = 0;

  apb_requester #(
    .AddrWidth(AW), .DataWidth(DW), .NumSel(NSEL), .SelLsb(SLSB), .TimeoutCycles(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
    .cmdAddr(cmdAddr), .cmdWData(cmdWData),
    .rspValid(rspValid), .rspReady(rspReady), .rspRData(rspRData), .rspErr(rspErr),
    .sel(sel), .enable(enable), .write(write), .addr(addr), .wData(wData),
    .rData(rData), .ready(ready), .subErr(subErr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  // Transaction model: no command / APB transfer open / response pending.
  int            m_phase;
  int            m_age;   // cycles since the command was accepted
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  int            m_idx;
  logic [DW-1:0] m_rdata;
  logic          m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [NSEL-1:0] exp_sel;
    exp_sel = (m_phase == 1) ? NSEL'(1 << m_idx) : '0;
    chk("cmdReady", 64'(cmdReady), 64'(m_phase == 0));
    chk("sel", 64'(sel), 64'(exp_sel));
    chk("enable", 64'(enable), 64'(m_phase == 1 && m_age >= 2));
    chk("rspValid", 64'(rspValid), 64'(m_phase == 2));
    if (m_phase == 1) begin
      chk("write", 64'(write), 64'(m_wr));
      chk("addr", 64'(addr), 64'(m_addr));
      chk("wData", 64'(wData), 64'(m_wd));
    end
    if (m_phase == 2) begin
      chk("rspRData", 64'(rspRData), 64'(m_rdata));
      chk("rspErr", 64'(rspErr), 64'(m_err));
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_update();
    if (m_phase == 0) begin
      if (cmdValid) begin
        m_wr   = cmdWrite;
        m_addr = cmdAddr;
        m_wd   = cmdWData;
        m_idx  = int'(cmdAddr[SLSB +: 2]);
        if (m_idx >= int'(NSEL)) begin
          m_phase = 2; m_rdata = '0; m_err = 1'b1;
        end else begin
          m_phase = 1; m_age = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (m_age >= 2) begin
        if (ready) begin
          m_phase = 2; m_rdata = m_wr ? '0 : rData; m_err = subErr;
        end else if (m_age - 1 == int'(TMO)) begin
          m_phase = 2; m_rdata = '0; m_err = 1'b1;
        end
      end
      m_age++;
    end else if (rspReady) begin
      m_phase = 0;
    end
  endtask

  task automatic step();
    compare();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdWData = '0;
    rspReady = 1'b0; rData = '0; ready = 1'b0; subErr = 1'b0;
  endtask

  int n_en;
  int rprob[4] = '{50, 15, 0, 85};

  initial begin
    reset = 1'b1;
    idle_inputs();
    m_phase = 0; m_age = 0; m_idx = 0; m_wr = 0; m_addr = '0; m_wd = '0;
    m_rdata = '0; m_err = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_sel", 64'(sel), 64'(0));
    chk("rst_enable", 64'(enable), 64'(0));
    chk("rst_rspValid", 64'(rspValid), 64'(0));
    chk("rst_rspErr", 64'(rspErr), 64'(0));
    chk("rst_rspRData", 64'(rspRData), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmdReady", 64'(cmdReady), 64'(1));

    // Zero-wait write to select 1; rData noise must not leak into the response.
    idle_inputs();
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 32'h0000_1004; cmdWData = 32'h0000_A5A5;
    ready = 1'b1; rData = 32'hDEAD_BEEF;
    step();
    cmdValid = 1'b0;
    chk("w0_sel_setup", 64'(sel), 64'(3'b010));
    chk("w0_en_setup", 64'(enable), 64'(0));
    step();
    chk("w0_en_access", 64'(enable), 64'(1));
    chk("w0_wdata", 64'(wData), 64'(32'h0000_A5A5));
    step();
    chk("w0_rspValid", 64'(rspValid), 64'(1));
    chk("w0_rspErr", 64'(rspErr), 64'(0));
    chk("w0_rspRData", 64'(rspRData), 64'(0));
    chk("w0_sel_resp", 64'(sel), 64'(0));
    rspReady = 1'b1;
    step();

    // Read with three wait states.
    idle_inputs();
    cmdValid = 1'b1; cmdAddr = 32'h0; rData = 32'h1234;
    step();
    cmdValid = 1'b0;
    step();
    n_en = 0;
    for (int i = 0; i < 4; i++) begin
      if (enable) n_en++;
      ready = (i == 3);
      step();
    end
    ready = 1'b0;
    chk("r3_enable_cycles", 64'(n_en), 64'(4));
    chk("r3_rspRData", 64'(rspRData), 64'(32'h1234));
    chk("r3_rspErr", 64'(rspErr), 64'(0));
    rspReady = 1'b1;
    step();

    // Peripheral error, then a stalled response.
    idle_inputs();
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 32'h0000_2008; cmdWData = 32'h55;
    ready = 1'b1; subErr = 1'b1;
    step();
    cmdValid = 1'b0;
    step();
    step();
    ready = 1'b0; subErr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("pe_rspErr", 64'(rspErr), 64'(1));
      chk("pe_cmdReady", 64'(cmdReady), 64'(0));
      step();
    end
    rspReady = 1'b1;
    step();

    // Timeout: ready never arrives.
    idle_inputs();
    cmdValid = 1'b1; cmdAddr = 32'h0000_1000; rData = 32'hFFFF;
    step();
    cmdValid = 1'b0;
    n_en = 0;
    for (int i = 0; i < 20; i++) begin
      if (enable) n_en++;
      step();
    end
    chk("to_access_cycles", 64'(n_en), 64'(16));
    chk("to_rspErr", 64'(rspErr), 64'(1));
    chk("to_rspRData", 64'(rspRData), 64'(0));
    chk("to_sel", 64'(sel), 64'(0));
    rspReady = 1'b1;
    step();

    // Ready on the 16th access cycle completes normally.
    idle_inputs();
    cmdValid = 1'b1; cmdAddr = 32'h0000_2000; rData = 32'h5A5A;
    step();
    cmdValid = 1'b0;
    n_en = 0;
    for (int i = 0; i < 20; i++) begin
      if (enable) n_en++;
      ready = enable && (n_en == 16);
      step();
    end
    ready = 1'b0;
    chk("to16_access_cycles", 64'(n_en), 64'(16));
    chk("to16_rspErr", 64'(rspErr), 64'(0));
    chk("to16_rspRData", 64'(rspRData), 64'(32'h5A5A));
    rspReady = 1'b1;
    step();

    // Decode error: select index 3 with only three peripherals.
    idle_inputs();
    cmdValid = 1'b1; cmdAddr = 32'h0000_3000;
    step();
    cmdValid = 1'b0;
    chk("de_rspValid", 64'(rspValid), 64'(1));
    chk("de_rspErr", 64'(rspErr), 64'(1));
    chk("de_sel", 64'(sel), 64'(0));
    rspReady = 1'b1;
    step();

    // Reset in the middle of ACCESS.
    idle_inputs();
    cmdValid = 1'b1; cmdAddr = 32'h0000_1000;
    step();
    cmdValid = 1'b0;
    step();
    step();
    chk("mr_enable_before", 64'(enable), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("mr_sel", 64'(sel), 64'(0));
    chk("mr_enable", 64'(enable), 64'(0));
    chk("mr_rspValid", 64'(rspValid), 64'(0));
    m_phase = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_cmdReady", 64'(cmdReady), 64'(1));
    cmdValid = 1'b1; cmdAddr = 32'h0000_1010; rData = 32'h77; ready = 1'b1;
    step();
    cmdValid = 1'b0;
    step();
    step();
    chk("mr_read_valid", 64'(rspValid), 64'(1));
    chk("mr_read_data", 64'(rspRData), 64'(32'h77));
    rspReady = 1'b1;
    step();

    // Random traffic in blocks of differing peripheral responsiveness.
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 150; c++) begin
        cmdValid = 1'($urandom_range(0, 1));
        cmdWrite = 1'($urandom_range(0, 1));
        cmdAddr  = $urandom;
        cmdWData = $urandom;
        rData    = $urandom;
        subErr   = ($urandom_range(0, 3) == 0);
        ready    = (int'($urandom_range(0, 99)) < rprob[b]);
        rspReady = ($urandom_range(0, 9) < 6);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
